mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Parametrised N-requestor arbiter between the processor-side caches (icache, dcache, future prefetch or victim-writeback units) and the single tagged memory bus.
- Replaces the fixed "dcache wins, else icache" combinational mux.
- Adds a selectable fixed/round-robin policy, starvation aging, and per-requestor outstanding-load limits.
- Routes tagged load data back only to the requestor that issued the load.

Parameters:
- NUM_REQ, 2, number of requestors; index NUM_REQ-1 has highest fixed priority (dcache).
- ARB_MODE, 0, 0 = fixed priority with aging; 1 = round-robin.
- MAX_WAIT, 8, cycles a pending requestor may be denied in mode 0 before it is forced to win.
- MAX_OUTSTANDING, 4, maximum unreturned loads per requestor; requestors at the limit are masked.
- TAG_W, 4, memory tag width; tag 0 means none.
- ADDR_W, 32, address width (XLEN).
- DATA_W, 64, memory data width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- req_command  in  NUM_REQ x 2  per requestor: BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2.
- req_addr  in  NUM_REQ x ADDR_W  per-requestor address.
- req_data  in  NUM_REQ x DATA_W  per-requestor store data.
- req_grant  out  NUM_REQ  one-hot, combinational; marks the requestor driving the bus this cycle.
- req_response  out  NUM_REQ x TAG_W  mem2proc_response steered to the granted requestor; 0 for all others.
- req_rdata  out  DATA_W  mem2proc_data broadcast.
- req_rtag  out  TAG_W  mem2proc_tag broadcast.
- req_rvalid  out  NUM_REQ  one-hot; owner of the returning tag.
- proc2mem_command  out  2  bus command.
- proc2mem_addr  out  ADDR_W  bus address.
- proc2mem_data  out  DATA_W  bus store data.
- mem2proc_response  in  TAG_W  acceptance tag; 0 = rejected.
- mem2proc_data  in  DATA_W  returning load data.
- mem2proc_tag  in  TAG_W  tag of returning data; 0 = none.
- unexpected_tag  out  1  sticky error flag.

Behaviour:
- Eligibility: requestor i is eligible when req_command[i] != BUS_NONE and it is not a LOAD with outstanding count at MAX_OUTSTANDING. Stores are never masked.
- Grant is combinational, same cycle. At most one grant bit set; none when no requestor is eligible.
- Bus outputs equal the granted requestor's command/addr/data. With no grant: command = BUS_NONE, addr = 0, data = 0.
- Mode 0:
  - Any eligible requestor with wait_cnt >= MAX_WAIT wins; ties go to the highest index.
  - Otherwise the highest eligible index wins.
  - wait_cnt[i] increments (saturating at MAX_WAIT) each cycle i is eligible but not granted with response != 0.
  - wait_cnt[i] clears when i is accepted or when i is not requesting.
- Mode 1:
  - rr_ptr marks the first index searched, scanning upward with wrap.
  - On acceptance (grant && mem2proc_response != 0), rr_ptr <= granted index + 1, modulo NUM_REQ.
  - On rejection, rr_ptr holds, so the same requestor retries first.
- Acceptance of a LOAD at posedge:
  - owner[mem2proc_response] <= granted index; valid bit set.
  - outstanding[granted] increments.
- Acceptance of a STORE: no table entry.
- Completion, each cycle mem2proc_tag != 0:
  - If entry valid: req_rvalid[owner] = 1 combinationally. At posedge, clear the entry and decrement outstanding[owner].
  - If entry invalid: req_rvalid = 0 and unexpected_tag <= 1. The flag stays set until reset.
- Simultaneous completion and allocation of the same tag in one cycle: clear first, then allocate; the entry ends valid with the new owner. Outstanding counts net correctly (owner +1/-1 in the same cycle nets to 0).
- Rejected request (response 0): no state change other than wait_cnt. The requestor must hold its command.
- Reset, asserted any time:
  - Owner table invalid; outstanding, wait_cnt and rr_ptr = 0; unexpected_tag = 0.
  - In-flight data returned after reset is flagged as unexpected.
  - All outputs combinationally derived from inputs and cleared state.

Test Plan:
- Req0 LOAD 0x100 and req1 LOAD 0x200, mode 0, response 3 → grant = 2'b10, bus addr 0x200, req_response[1] = 3. Tag 3 returns data 0xDEAD → req_rvalid = 2'b10, req_rdata = 0xDEAD.
- Mode 0, MAX_WAIT = 8, req1 loads continuously, req0 loading, all accepted → req0 granted on cycle 9, then req1 resumes.
- Mode 1, both requestors continuously loading, all accepted → grants alternate 01,10,01,10. A rejected cycle repeats the same grant next cycle.
- MAX_OUTSTANDING = 4: req0 issues 4 accepted loads with no returns → 5th load not granted. After one tag returns, granted next cycle.
- Tag 5 returns while tag 5 is reallocated to req1 in the same cycle (prior owner req0) → req_rvalid = 2'b01; owner[5] = 1 afterwards; outstanding counts updated accordingly.
- mem2proc_tag = 7 with no entry → unexpected_tag = 1, no rvalid. Assert reset mid-traffic → grants drop to 0, flag cleared.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   N-requestor arbiter in front of the single tagged memory bus. Selects one
//   requestor per cycle (fixed priority with starvation aging, or round-robin),
//   drives its command onto the bus, steers the acceptance tag back to it, and
//   routes returning load data to whichever requestor issued the tag.
//
// Ports
//   clock, reset          system clock; asynchronous active-low reset
//   req_command/addr/data per-requestor bus request (NONE=0, LOAD=1, STORE=2)
//   req_grant             one-hot, combinational: requestor owning the bus now
//   req_response          acceptance tag steered to the granted requestor
//   req_rdata/req_rtag    returning data/tag broadcast to all requestors
//   req_rvalid            one-hot: owner of the tag currently returning
//   proc2mem_*            bus command/address/store data
//   mem2proc_*            acceptance tag, returning data and its tag
//   unexpected_tag        sticky: a tag returned with no owner on record
module mem_bus_arbiter #(
    parameter int NUM_REQ         = 2,
    parameter int ARB_MODE        = 0,
    parameter int MAX_WAIT        = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_W           = 4,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 64
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0][1:0]        req_command,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_grant,
    output logic [NUM_REQ-1:0][TAG_W-1:0]  req_response,
    output logic [DATA_W-1:0]              req_rdata,
    output logic [TAG_W-1:0]               req_rtag,
    output logic [NUM_REQ-1:0]             req_rvalid,
    output logic [1:0]                     proc2mem_command,
    output logic [ADDR_W-1:0]              proc2mem_addr,
    output logic [DATA_W-1:0]              proc2mem_data,
    input  logic [TAG_W-1:0]               mem2proc_response,
    input  logic [DATA_W-1:0]              mem2proc_data,
    input  logic [TAG_W-1:0]               mem2proc_tag,
    output logic                           unexpected_tag
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam int NTAG   = 1 << TAG_W;

    logic [NTAG-1:0]   r_tag_valid;
    logic [IDX_W-1:0]  r_tag_owner   [NTAG];
    logic [OUT_W-1:0]  r_outstanding [NUM_REQ];
    logic [WAIT_W-1:0] r_wait        [NUM_REQ];
    logic [IDX_W-1:0]  r_rr_ptr;
    logic              r_unexpected;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_gvalid;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_any_aged;
    logic [IDX_W-1:0]   w_aged_idx;
    logic               w_accept;
    logic               w_gload;
    logic               w_comp;
    logic [IDX_W-1:0]   w_comp_owner;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;

    // (ptr + off) mod NUM_REQ; both operands are below NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] ptr,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(ptr) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    // Loads at the outstanding limit are masked; stores never are. Nothing is
    // eligible while reset is held so grants drop immediately.
    always_comb begin
        w_elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = reset && (req_command[i] != BUS_NONE) &&
                        !((req_command[i] == BUS_LOAD) &&
                          (r_outstanding[i] >= OUT_W'(MAX_OUTSTANDING)));
        end
    end

    always_comb begin
        w_gvalid   = 1'b0;
        w_gidx     = '0;
        w_any_aged = 1'b0;
        w_aged_idx = '0;
        if (ARB_MODE == 0) begin
            // Ascending scan, later hits overwrite: highest index wins.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_elig[i]) begin
                    w_gvalid = 1'b1;
                    w_gidx   = IDX_W'(i);
                end
                if (w_elig[i] && (r_wait[i] >= WAIT_W'(MAX_WAIT))) begin
                    w_any_aged = 1'b1;
                    w_aged_idx = IDX_W'(i);
                end
            end
            if (w_any_aged) w_gidx = w_aged_idx;
        end else begin
            // Scan offsets from farthest to nearest so the first eligible
            // index at or after rr_ptr is the one left standing.
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (w_elig[rr_idx(r_rr_ptr, NUM_REQ - 1 - k)]) begin
                    w_gvalid = 1'b1;
                    w_gidx   = rr_idx(r_rr_ptr, NUM_REQ - 1 - k);
                end
            end
        end
    end

    assign w_accept     = w_gvalid && (mem2proc_response != '0);
    assign w_gload      = w_gvalid && (req_command[w_gidx] == BUS_LOAD);
    assign w_comp       = (mem2proc_tag != '0) && r_tag_valid[mem2proc_tag];
    assign w_comp_owner = r_tag_owner[mem2proc_tag];

    always_comb begin
        req_grant        = '0;
        req_response     = '0;
        req_rvalid       = '0;
        w_inc            = '0;
        w_dec            = '0;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (w_gvalid) begin
            req_grant[w_gidx]    = 1'b1;
            req_response[w_gidx] = mem2proc_response;
            proc2mem_command     = req_command[w_gidx];
            proc2mem_addr        = req_addr[w_gidx];
            proc2mem_data        = req_data[w_gidx];
        end
        if (w_comp) begin
            req_rvalid[w_comp_owner] = 1'b1;
            w_dec[w_comp_owner]      = 1'b1;
        end
        if (w_accept && w_gload) w_inc[w_gidx] = 1'b1;
    end

    assign req_rdata      = mem2proc_data;
    assign req_rtag       = mem2proc_tag;
    assign unexpected_tag = r_unexpected;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_valid  <= '0;
            r_rr_ptr     <= '0;
            r_unexpected <= 1'b0;
            for (int unsigned t = 0; t < NTAG; t++) r_tag_owner[t] <= '0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                r_outstanding[i] <= '0;
                r_wait[i]        <= '0;
            end
        end else begin
            if ((mem2proc_tag != '0) && !r_tag_valid[mem2proc_tag]) r_unexpected <= 1'b1;
            // Clear precedes allocate so a tag retired and reissued in the
            // same cycle ends up valid under its new owner.
            if (w_comp) r_tag_valid[mem2proc_tag] <= 1'b0;
            if (w_accept && w_gload) begin
                r_tag_valid[mem2proc_response] <= 1'b1;
                r_tag_owner[mem2proc_response] <= w_gidx;
            end
            if ((ARB_MODE != 0) && w_accept) r_rr_ptr <= rr_idx(w_gidx, 1);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_outstanding[i] <= r_outstanding[i] + OUT_W'(1);
                else if (w_dec[i] && !w_inc[i])
                    r_outstanding[i] <= r_outstanding[i] - OUT_W'(1);

                if ((req_command[i] == BUS_NONE) || (w_accept && (w_gidx == IDX_W'(i))))
                    r_wait[i] <= '0;
                else if (w_elig[i] && (r_wait[i] < WAIT_W'(MAX_WAIT)))
                    r_wait[i] <= r_wait[i] + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] L = 2'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index [k] selects DUT k: dut0 = fixed priority with aging, dut1 = round-robin.
    logic [1:0]              rst_n;
    logic [1:0][1:0][1:0]    cmd;
    logic [1:0][1:0][31:0]   addr;
    logic [1:0][1:0][63:0]   wdata;
    logic [1:0][3:0]         resp, tag;
    logic [1:0][63:0]        rdata;
    logic [1:0][1:0]         grant, rvalid, pcmd;
    logic [1:0][1:0][3:0]    rresp;
    logic [1:0][63:0]        ordata, pdata;
    logic [1:0][3:0]         ortag;
    logic [1:0][31:0]        paddr;
    logic [1:0]              unexp;

    mem_bus_arbiter #(.NUM_REQ(2), .ARB_MODE(0), .MAX_WAIT(8), .MAX_OUTSTANDING(4),
                      .TAG_W(4), .ADDR_W(32), .DATA_W(64)) dut0 (
        .clock(clk), .reset(rst_n[0]),
        .req_command(cmd[0]), .req_addr(addr[0]), .req_data(wdata[0]),
        .req_grant(grant[0]), .req_response(rresp[0]), .req_rdata(ordata[0]),
        .req_rtag(ortag[0]), .req_rvalid(rvalid[0]),
        .proc2mem_command(pcmd[0]), .proc2mem_addr(paddr[0]), .proc2mem_data(pdata[0]),
        .mem2proc_response(resp[0]), .mem2proc_data(rdata[0]), .mem2proc_tag(tag[0]),
        .unexpected_tag(unexp[0]));

    mem_bus_arbiter #(.NUM_REQ(2), .ARB_MODE(1), .MAX_WAIT(8), .MAX_OUTSTANDING(4),
                      .TAG_W(4), .ADDR_W(32), .DATA_W(64)) dut1 (
        .clock(clk), .reset(rst_n[1]),
        .req_command(cmd[1]), .req_addr(addr[1]), .req_data(wdata[1]),
        .req_grant(grant[1]), .req_response(rresp[1]), .req_rdata(ordata[1]),
        .req_rtag(ortag[1]), .req_rvalid(rvalid[1]),
        .proc2mem_command(pcmd[1]), .proc2mem_addr(paddr[1]), .proc2mem_data(pdata[1]),
        .mem2proc_response(resp[1]), .mem2proc_data(rdata[1]), .mem2proc_tag(tag[1]),
        .unexpected_tag(unexp[1]));

    typedef struct packed {
        logic [31:0]     cyc;
        logic [1:0]      grant;
        logic [1:0]      pcmd;
        logic [31:0]     paddr;
        logic [63:0]     pdata;
        logic [1:0][3:0] resp;
        logic [1:0]      rvalid;
        logic [63:0]     rdata;
        logic [3:0]      rtag;
        logic            unexp;
    } ev_t;

    ev_t sb0[$];
    ev_t sb1[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_bad = 0;
    logic [1:0] prev_unexp = 2'b00;

    always @(posedge clk) cyc <= cyc + 1;

    // Drives one cycle of stimulus on DUT k and queues the hand-computed
    // expectation; bus fields follow from the expected grant.
    task automatic drive(input int k,
                         input logic [1:0] c1, input logic [31:0] a1,
                         input logic [1:0] c0, input logic [31:0] a0,
                         input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] rd,
                         input logic [1:0] eg, input logic [1:0] erv, input logic eu);
        ev_t e;
        @(posedge clk);
        #1;
        cmd[k][1] = c1; addr[k][1] = a1; wdata[k][1] = {32'hDA7A0001, a1};
        cmd[k][0] = c0; addr[k][0] = a0; wdata[k][0] = {32'hDA7A0000, a0};
        resp[k] = rsp; tag[k] = tg; rdata[k] = rd;
        e = '0;
        e.cyc = 32'(cyc); e.grant = eg; e.rvalid = erv; e.unexp = eu;
        e.rdata = rd; e.rtag = tg;
        if (eg == 2'b10) begin
            e.pcmd = c1; e.paddr = a1; e.pdata = {32'hDA7A0001, a1}; e.resp[1] = rsp;
        end else if (eg == 2'b01) begin
            e.pcmd = c0; e.paddr = a0; e.pdata = {32'hDA7A0000, a0}; e.resp[0] = rsp;
        end
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    // Monitor: compares every scheduled cycle, and flags any output activity
    // on a cycle with nothing scheduled.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            ev_t o, e;
            logic have, act;
            o.cyc = 32'(cyc); o.grant = grant[k]; o.pcmd = pcmd[k]; o.paddr = paddr[k];
            o.pdata = pdata[k]; o.resp = rresp[k]; o.rvalid = rvalid[k];
            o.rdata = ordata[k]; o.rtag = ortag[k]; o.unexp = unexp[k];
            act  = (o.grant != 2'b00) || (o.rvalid != 2'b00) || (o.unexp != prev_unexp[k]);
            have = 1'b0;
            e    = '0;
            if (k == 0 && sb0.size() > 0 && sb0[0].cyc == 32'(cyc)) begin
                have = 1'b1; e = sb0.pop_front();
            end else if (k == 1 && sb1.size() > 0 && sb1[0].cyc == 32'(cyc)) begin
                have = 1'b1; e = sb1.pop_front();
            end
            if (have) begin
                n_cmp++;
                if (o != e) begin
                    n_bad++;
                    $display("FAIL dut%0d cyc%0d: got grant=%b cmd=%0d addr=%h data=%h resp=%h rvalid=%b rdata=%h rtag=%h unexp=%b / required grant=%b cmd=%0d addr=%h data=%h resp=%h rvalid=%b rdata=%h rtag=%h unexp=%b",
                             k, cyc, o.grant, o.pcmd, o.paddr, o.pdata, o.resp, o.rvalid, o.rdata, o.rtag, o.unexp,
                             e.grant, e.pcmd, e.paddr, e.pdata, e.resp, e.rvalid, e.rdata, e.rtag, e.unexp);
                end
            end else if (act) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut%0d cyc%0d unscheduled output: got grant=%b rvalid=%b unexp=%b, required idle",
                         k, cyc, o.grant, o.rvalid, o.unexp);
            end
            prev_unexp[k] = o.unexp;
        end
    end

    initial begin
        rst_n = 2'b00;
        cmd = '0; addr = '0; wdata = '0; resp = '0; tag = '0; rdata = '0;

        // Reset state: requests present while in reset see no grant.
        drive(0, L, 32'h200, L, 32'h100, 4'd3, 4'd0, 64'd0, 2'b00, 2'b00, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd3, 4'd0, 64'd0, 2'b00, 2'b00, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'd0, 2'b00, 2'b00, 1'b0);
        drive(1, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'd0, 2'b00, 2'b00, 1'b0);
        rst_n = 2'b11;

        // Round-robin: alternation, a rejected grant repeats.
        drive(1, L, 32'h200, L, 32'h100, 4'd1, 4'd0, 64'h11, 2'b01, 2'b00, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd1, 4'd1, 64'h12, 2'b10, 2'b01, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd1, 4'd1, 64'h13, 2'b01, 2'b10, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd0, 4'd1, 64'h14, 2'b10, 2'b01, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd1, 4'd0, 64'h15, 2'b10, 2'b00, 1'b0);
        drive(1, L, 32'h200, L, 32'h100, 4'd1, 4'd1, 64'h16, 2'b01, 2'b10, 1'b0);
        drive(1, N, 32'h0, N, 32'h0, 4'd0, 4'd1, 64'h17, 2'b00, 2'b01, 1'b0);
        drive(1, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'h0, 2'b00, 2'b00, 1'b0);

        // Fixed priority: dcache wins, tagged data returns to it.
        drive(0, L, 32'h200, L, 32'h100, 4'd3, 4'd0, 64'h0, 2'b10, 2'b00, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd3, 64'hDEAD, 2'b00, 2'b10, 1'b0);

        // Aging: req0 denied 8 times, forced to win on the 9th cycle.
        for (int k = 1; k <= 11; k++) begin
            drive(0, L, 32'h200, L, 32'h100, 4'd1, (k == 1) ? 4'd0 : 4'd1, 64'(k),
                  (k == 9) ? 2'b01 : 2'b10,
                  (k == 1) ? 2'b00 : ((k == 10) ? 2'b01 : 2'b10), 1'b0);
        end
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd1, 64'h0, 2'b00, 2'b10, 1'b0);

        // Outstanding limit: four accepted loads, fifth masked until a return.
        for (int j = 0; j < 4; j++)
            drive(0, N, 32'h0, L, 32'h140, 4'(2 + j), 4'd0, 64'h0, 2'b01, 2'b00, 1'b0);
        drive(0, N, 32'h0, L, 32'h140, 4'd6, 4'd0, 64'h0, 2'b00, 2'b00, 1'b0);
        drive(0, N, 32'h0, L, 32'h140, 4'd6, 4'd2, 64'h22, 2'b00, 2'b01, 1'b0);
        drive(0, N, 32'h0, L, 32'h140, 4'd7, 4'd0, 64'h0, 2'b01, 2'b00, 1'b0);

        // Tag 5 retires to req0 and is reissued to req1 in the same cycle.
        drive(0, L, 32'h200, N, 32'h0, 4'd5, 4'd5, 64'h55, 2'b10, 2'b01, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd5, 64'h56, 2'b00, 2'b10, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd3, 64'h33, 2'b00, 2'b01, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd4, 64'h44, 2'b00, 2'b01, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd7, 64'h77, 2'b00, 2'b01, 1'b0);

        // Unknown tag sets the sticky flag; reset mid-traffic clears it.
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd7, 64'h78, 2'b00, 2'b00, 1'b0);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'h0, 2'b00, 2'b00, 1'b1);
        drive(0, L, 32'h200, L, 32'h100, 4'd1, 4'd0, 64'h0, 2'b10, 2'b00, 1'b1);
        drive(0, L, 32'h200, L, 32'h100, 4'd1, 4'd0, 64'h0, 2'b00, 2'b00, 1'b0);
        rst_n[0] = 1'b0;
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd1, 64'hBEEF, 2'b00, 2'b00, 1'b0);
        rst_n[0] = 1'b1;
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'h0, 2'b00, 2'b00, 1'b1);
        drive(0, N, 32'h0, N, 32'h0, 4'd0, 4'd0, 64'h0, 2'b00, 2'b00, 1'b1);

        @(posedge clk);
        @(posedge clk);
        if (sb0.size() != 0 || sb1.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d/%0d unchecked expectations, required 0/0",
                     sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
